// File: rtl/tdm2p.sv
// TDM receive deserializer: oversamples an 8ch x 32b TDM stream (256 bits/frame)
// into clk and delivers each complete frame as a 256-bit parallel word.

module tdm2p_sync #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);
  logic [DEPTH-1:0] ff;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) ff <= '0;
    else       ff <= {ff[DEPTH-2:0], d};
  end

  assign q = ff[DEPTH-1];
endmodule

module tdm2p #(
  parameter int SYNC_FLOPS  = 2,
  parameter bit SAMPLE_RISE = 1'b1
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         enable,
  input  logic         sclk,
  input  logic         fs,
  input  logic         tdmin,
  output logic         valid,
  output logic [255:0] pdata,
  output logic         locked,
  output logic         frameErrIncr
);
  localparam int NSIG = 3;

  typedef enum logic {HUNT, RECV} state_t;

  logic [NSIG-1:0] raw, syn;
  logic            sclk_s, fs_s, tdmin_s, sclk_d, sev;

  assign raw = {tdmin, fs, sclk};

  genvar g;
  generate
    for (g = 0; g < NSIG; g++) begin : g_sync
      tdm2p_sync #(.DEPTH(SYNC_FLOPS)) u_sync (
        .clk  (clk),
        .rstn (rstn),
        .d    (raw[g]),
        .q    (syn[g])
      );
    end
  endgenerate

  assign {tdmin_s, fs_s, sclk_s} = syn;

  // Edge history belongs with the synchronizers: it keeps running while
  // disabled so re-enabling never sees a stale edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) sclk_d <= 1'b0;
    else       sclk_d <= sclk_s;
  end

  assign sev = SAMPLE_RISE ? (sclk_s & ~sclk_d) : (~sclk_s & sclk_d);

  state_t       state_q, state_n;
  logic [7:0]   idx_q, idx_n;
  logic [255:0] shreg_q, shreg_n;
  logic [255:0] pdata_q, pdata_n;
  logic         valid_q, valid_n;
  logic         locked_q, locked_n;
  logic         err_q, err_n;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= HUNT;
      idx_q    <= '0;
      shreg_q  <= '0;
      pdata_q  <= '0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else if (!enable) begin
      state_q  <= HUNT;
      idx_q    <= '0;
      shreg_q  <= '0;
      pdata_q  <= '0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_n;
      idx_q    <= idx_n;
      shreg_q  <= shreg_n;
      pdata_q  <= pdata_n;
      valid_q  <= valid_n;
      locked_q <= locked_n;
      err_q    <= err_n;
    end
  end

  always_comb begin
    state_n  = state_q;
    idx_n    = idx_q;
    shreg_n  = shreg_q;
    pdata_n  = pdata_q;
    valid_n  = 1'b0;
    locked_n = locked_q;
    err_n    = 1'b0;
    case (state_q)
      HUNT: begin
        if (sev && fs_s) begin
          shreg_n[0] = tdmin_s;
          idx_n      = 8'd1;
          state_n    = RECV;
        end
      end
      RECV: begin
        if (sev) begin
          if (fs_s) begin
            // FS anywhere but bit 0 is an error, but the bit still starts a frame
            if (idx_q != 8'd0) begin
              err_n    = 1'b1;
              locked_n = 1'b0;
            end
            shreg_n[0] = tdmin_s;
            idx_n      = 8'd1;
          end else if (idx_q == 8'd0) begin
            err_n    = 1'b1;
            locked_n = 1'b0;
            state_n  = HUNT;
          end else if (idx_q == 8'd255) begin
            pdata_n  = {tdmin_s, shreg_q[254:0]};
            valid_n  = 1'b1;
            locked_n = 1'b1;
            idx_n    = 8'd0;
          end else begin
            shreg_n[idx_q] = tdmin_s;
            idx_n          = idx_q + 8'd1;
          end
        end
      end
      default: state_n = HUNT;
    endcase
  end

  assign valid        = valid_q;
  assign pdata        = pdata_q;
  assign locked       = locked_q;
  assign frameErrIncr = err_q;
endmodule

// File: tb/tb_tdm2p.sv
// Directed bench for tdm2p: frame table on an 8:1 rising-edge instance,
// hand sequences for enable/reset, and a 4:1 falling-edge 3-flop instance.

module tb_tdm2p;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rstn, enable, sclk, fs, tdmin;
  logic         valid, locked, ferr;
  logic [255:0] pdata;
  logic         sclk2, fs2, tdm2;
  logic         valid2, locked2, ferr2;
  logic [255:0] pdata2;

  tdm2p #(.SYNC_FLOPS(2), .SAMPLE_RISE(1'b1)) u_a (
    .clk(clk), .rstn(rstn), .enable(enable), .sclk(sclk), .fs(fs), .tdmin(tdmin),
    .valid(valid), .pdata(pdata), .locked(locked), .frameErrIncr(ferr)
  );

  tdm2p #(.SYNC_FLOPS(3), .SAMPLE_RISE(1'b0)) u_b (
    .clk(clk), .rstn(rstn), .enable(enable), .sclk(sclk2), .fs(fs2), .tdmin(tdm2),
    .valid(valid2), .pdata(pdata2), .locked(locked2), .frameErrIncr(ferr2)
  );

  int           ncmp = 0, nfail = 0;
  int           vcnt = 0, ecnt = 0, vcnt2 = 0, ecnt2 = 0;
  logic [255:0] lastp = '0, lastp2 = '0;
  logic         seen_valid = 1'b0, early_lock = 1'b0, both_seen = 1'b0;

  always @(negedge clk) begin
    if (valid) begin vcnt <= vcnt + 1; lastp <= pdata; seen_valid <= 1'b1; end
    if (ferr) ecnt <= ecnt + 1;
    if (valid && ferr) both_seen <= 1'b1;
    if (valid2 && ferr2) both_seen <= 1'b1;
    if (locked && !seen_valid && !valid) early_lock <= 1'b1;
    if (valid2) begin vcnt2 <= vcnt2 + 1; lastp2 <= pdata2; end
    if (ferr2) ecnt2 <= ecnt2 + 1;
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clkn(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // 8:1 stream, data launched with the falling sclk edge
  task automatic send_bit_a(input logic f, input logic d);
    sclk = 1'b0; fs = f; tdmin = d;
    clkn(4);
    sclk = 1'b1;
    clkn(4);
  endtask

  task automatic send_a(input logic [255:0] d, input int fa, input int fb,
                        input int from, input int to);
    for (int i = from; i <= to; i++) send_bit_a((i == fa) || (i == fb), d[i]);
  endtask

  // 4:1 stream, data launched with the rising sclk edge
  task automatic send_bit_b(input logic f, input logic d);
    sclk2 = 1'b1; fs2 = f; tdm2 = d;
    clkn(2);
    sclk2 = 1'b0;
    clkn(2);
  endtask

  typedef struct {
    logic [255:0] data;
    int           fsa;
    int           fsb;
    int           ev;
    int           ee;
    logic         elock;
    logic [255:0] ep;
  } rec_t;

  rec_t tbl[7];

  initial begin
    logic [255:0] P, Q, R, S, T, U, V, W, AB;
    int v0, e0, lat;

    P  = {16{16'h55AA}};   // bit i = i[0]^i[3]
    Q  = {8{32'hDEADBEEF}};
    R  = {8{32'h12345678}};
    S  = {8{32'h0F0FA5C3}};
    T  = {8{32'hCAFE1234}};
    U  = {8{32'h8421F00D}};
    V  = {8{32'h3C965A01}};
    W  = {8{32'h7E81BD42}};
    AB = {32{8'hA5}};

    tbl[0] = '{P,   0,  -1, 1, 0, 1'b1, P};
    tbl[1] = '{P,   0,  -1, 1, 0, 1'b1, P};
    tbl[2] = '{Q,  -1,  -1, 0, 1, 1'b0, P};
    tbl[3] = '{Q,   0,  -1, 1, 0, 1'b1, Q};
    tbl[4] = '{R,   0, 100, 0, 1, 1'b0, Q};
    tbl[5] = '{S, 100,  -1, 1, 0, 1'b1, {S[99:0], R[255:100]}};
    tbl[6] = '{T, 100,  -1, 1, 0, 1'b1, {T[99:0], S[255:100]}};

    rstn = 1'b0; enable = 1'b1; sclk = 1'b0; fs = 1'b0; tdmin = 1'b0;
    sclk2 = 1'b1; fs2 = 1'b0; tdm2 = 1'b0;
    clkn(3);
    chk("rst_valid", valid, 0);
    chk("rst_locked", locked, 0);
    chk("rst_ferr", ferr, 0);
    chk("rst_pdata", pdata, 0);
    chk("rst_b_out", {valid2, locked2, ferr2}, 0);
    rstn = 1'b1;
    clkn(3);

    for (int k = 0; k < 7; k++) begin
      v0 = vcnt; e0 = ecnt;
      send_a(tbl[k].data, tbl[k].fsa, tbl[k].fsb, 0, 255);
      chk($sformatf("rec%0d_valid_cnt", k), vcnt - v0, tbl[k].ev);
      chk($sformatf("rec%0d_err_cnt", k), ecnt - e0, tbl[k].ee);
      chk($sformatf("rec%0d_locked", k), locked, tbl[k].elock);
      chk($sformatf("rec%0d_pdata", k), lastp, tbl[k].ep);
    end

    // enable dropped mid-frame while locked
    v0 = vcnt; e0 = ecnt;
    send_a(U, -1, -1, 0, 49);
    enable = 1'b0;
    clkn(1);
    chk("en_valid", valid, 0);
    chk("en_locked", locked, 0);
    chk("en_pdata", pdata, 0);
    clkn(9);
    enable = 1'b1;
    send_a(U, -1, -1, 50, 99);
    chk("en_no_valid_hunt", vcnt - v0, 0);
    send_a(U, 0, -1, 0, 255);
    chk("en_valid_cnt", vcnt - v0, 1);
    chk("en_err_cnt", ecnt - e0, 0);
    chk("en_pdata_full", lastp, U);
    chk("en_locked_after", locked, 1);

    // async reset during bit 200
    v0 = vcnt; e0 = ecnt;
    send_a(V, 0, -1, 0, 199);
    sclk = 1'b0; fs = 1'b0; tdmin = V[200];
    clkn(1);
    #2 rstn = 1'b0;
    #1;
    chk("arst_locked", locked, 0);
    chk("arst_pdata", pdata, 0);
    chk("arst_valid", valid, 0);
    clkn(3);
    rstn = 1'b1;
    clkn(3);
    sclk = 1'b1;
    clkn(4);
    send_a(V, -1, -1, 201, 255);
    chk("arst_no_valid", vcnt - v0, 0);
    send_a(W, 0, -1, 0, 255);
    chk("arst_valid_cnt", vcnt - v0, 1);
    chk("arst_pdata_full", lastp, W);

    // 4:1, falling-edge capture, 3-flop synchronizer
    lat = 0;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 255; i++) send_bit_b(i == 0, AB[i]);
      sclk2 = 1'b1; fs2 = 1'b0; tdm2 = AB[255];
      clkn(2);
      sclk2 = 1'b0;
      if (f == 1) begin
        for (int n = 1; n <= 8; n++) begin
          @(posedge clk); #1;
          if (valid2) begin lat = n; break; end
        end
      end else begin
        clkn(2);
      end
      sclk2 = 1'b1;
      clkn(2);
    end
    chk("b_valid_cnt", vcnt2, 2);
    chk("b_err_cnt", ecnt2, 0);
    chk("b_pdata", lastp2, AB);
    chk("b_locked", locked2, 1);
    chk("b_sev_latency", lat, 4);

    chk("valid_err_overlap", both_seen, 0);
    chk("locked_before_first_valid", early_lock, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
